// File: rtl/age_rs_pkg.sv
// age_rs_pkg: shared op codes and sizing constants for the age-ordered reservation station
package age_rs_pkg;
  localparam int ROB_WIDTH_BIT = 4;
  localparam int RS_DEPTH = 8;
  typedef enum logic [5:0] {
    OP_LUI = 6'd0,
    OP_AUIPC = 6'd1,
    OP_JAL = 6'd2,
    OP_JALR = 6'd3,
    OP_BEQ = 6'd4,
    OP_BNE = 6'd5,
    OP_BLT = 6'd6,
    OP_BGE = 6'd7,
    OP_BLTU = 6'd8,
    OP_BGEU = 6'd9,
    OP_ADDI = 6'd18,
    OP_SLTI = 6'd19,
    OP_SLTIU = 6'd20,
    OP_XORI = 6'd21,
    OP_ORI = 6'd22,
    OP_ANDI = 6'd23,
    OP_SLLI = 6'd24,
    OP_SRLI = 6'd25,
    OP_SRAI = 6'd26,
    OP_ADD = 6'd27,
    OP_SUB = 6'd28,
    OP_SLL = 6'd29,
    OP_SLT = 6'd30,
    OP_SLTU = 6'd31,
    OP_XOR = 6'd32,
    OP_SRL = 6'd33,
    OP_SRA = 6'd34,
    OP_OR = 6'd35,
    OP_AND = 6'd36
  } op_e;
endpackage

// File: rtl/rs_alu.sv
// rs_alu: combinational result and branch/jump target for one issuing entry
module rs_alu
  import age_rs_pkg::*;
(
  input  logic [5:0]  op,
  input  logic [31:0] vj,
  input  logic [31:0] vk,
  input  logic [31:0] imm,
  input  logic [31:0] pc,
  output logic [31:0] value,
  output logic [31:0] target
);
  logic [31:0] link, br_tgt;
  logic [4:0] shi, shr;
  logic taken, is_br;
  assign link = pc + 32'd4;
  assign br_tgt = pc + imm;
  assign shi = imm[4:0];
  assign shr = vk[4:0];
  always_comb begin
    taken = 1'b0;
    is_br = 1'b1;
    case (op)
      OP_BEQ: taken = vj == vk;
      OP_BNE: taken = vj != vk;
      OP_BLT: taken = $signed(vj) < $signed(vk);
      OP_BGE: taken = $signed(vj) >= $signed(vk);
      OP_BLTU: taken = vj < vk;
      OP_BGEU: taken = vj >= vk;
      default: is_br = 1'b0;
    endcase
  end
  always_comb begin
    value = is_br ? {31'd0, taken} : 32'd0;
    target = is_br ? br_tgt : 32'd0;
    case (op)
      OP_LUI, OP_AUIPC: value = imm;
      OP_JAL: begin
        value = link;
        target = br_tgt;
      end
      OP_JALR: begin
        value = link;
        target = (vj + imm) & ~32'd1;
      end
      OP_ADDI: value = vj + imm;
      OP_SLTI: value = {31'd0, $signed(vj) < $signed(imm)};
      OP_SLTIU: value = {31'd0, vj < imm};
      OP_XORI: value = vj ^ imm;
      OP_ORI: value = vj | imm;
      OP_ANDI: value = vj & imm;
      OP_SLLI: value = vj << shi;
      OP_SRLI: value = vj >> shi;
      OP_SRAI: value = $signed(vj) >>> shi;
      OP_ADD: value = vj + vk;
      OP_SUB: value = vj - vk;
      OP_SLL: value = vj << shr;
      OP_SLT: value = {31'd0, $signed(vj) < $signed(vk)};
      OP_SLTU: value = {31'd0, vj < vk};
      OP_XOR: value = vj ^ vk;
      OP_SRL: value = vj >> shr;
      OP_SRA: value = $signed(vj) >>> shr;
      OP_OR: value = vj | vk;
      OP_AND: value = vj & vk;
      default: ;
    endcase
  end
endmodule

// File: rtl/age_rs.sv
// age_rs: age-ordered reservation station with CDB/issue wakeup and a registered result port
module age_rs
  import age_rs_pkg::*;
#(
  parameter int DEPTH = RS_DEPTH,
  parameter int NUM_CDB = 2,
  parameter int ROB_ID_W = ROB_WIDTH_BIT
) (
  input  logic                         clk_in,
  input  logic                         rst_in,
  input  logic                         rdy_in,
  input  logic                         flush,
  input  logic                         disp_valid,
  output logic                         disp_ready,
  input  logic [5:0]                   disp_op,
  input  logic [ROB_ID_W-1:0]          disp_rob,
  input  logic [31:0]                  disp_imm,
  input  logic [31:0]                  disp_pc,
  input  logic                         disp_j,
  input  logic                         disp_k,
  input  logic [31:0]                  disp_vj,
  input  logic [31:0]                  disp_vk,
  input  logic [ROB_ID_W-1:0]          disp_qj,
  input  logic [ROB_ID_W-1:0]          disp_qk,
  input  logic [NUM_CDB-1:0]           cdb_valid,
  input  logic [NUM_CDB*ROB_ID_W-1:0]  cdb_rob,
  input  logic [NUM_CDB*32-1:0]        cdb_value,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [ROB_ID_W-1:0]          out_rob,
  output logic [31:0]                  out_value,
  output logic [31:0]                  out_target,
  output logic [$clog2(DEPTH+1)-1:0]   count
);
  localparam int IW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  logic [DEPTH-1:0] e_valid, e_j, e_k, rdy;
  logic [DEPTH-1:0] older [DEPTH];
  logic [5:0] e_op [DEPTH];
  logic [ROB_ID_W-1:0] e_rob [DEPTH];
  logic [ROB_ID_W-1:0] e_qj [DEPTH];
  logic [ROB_ID_W-1:0] e_qk [DEPTH];
  logic [31:0] e_imm [DEPTH];
  logic [31:0] e_pc [DEPTH];
  logic [31:0] e_vj [DEPTH];
  logic [31:0] e_vk [DEPTH];
  logic [ROB_ID_W-1:0] tag_j [DEPTH+1];
  logic [ROB_ID_W-1:0] tag_k [DEPTH+1];
  logic [31:0] wake_j [DEPTH+1];
  logic [31:0] wake_k [DEPTH+1];
  logic [DEPTH:0] hit_j, hit_k;
  logic [IW-1:0] sel, free_idx;
  logic any_rdy, issue, disp_fire;
  logic [31:0] alu_value, alu_target;
  assign rdy = e_valid & e_j & e_k;
  assign disp_ready = count < CW'(DEPTH);
  assign disp_fire = rdy_in && !flush && disp_valid && disp_ready;
  assign issue = rdy_in && !flush && any_rdy && (!out_valid || out_ready);
  // older[i] marks the entries dispatched before entry i; the oldest ready entry has none of them ready
  always_comb begin
    sel = '0;
    any_rdy = 1'b0;
    free_idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (rdy[i] && !(|(rdy & older[i]))) begin
        sel = IW'(i);
        any_rdy = 1'b1;
      end
    end
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!e_valid[i]) free_idx = IW'(i);
    end
  end
  // slot DEPTH is the operand pair arriving on the dispatch port
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      tag_j[i] = e_qj[i];
      tag_k[i] = e_qk[i];
    end
    tag_j[DEPTH] = disp_qj;
    tag_k[DEPTH] = disp_qk;
    for (int i = 0; i <= DEPTH; i++) begin
      hit_j[i] = issue && e_rob[sel] == tag_j[i];
      hit_k[i] = issue && e_rob[sel] == tag_k[i];
      wake_j[i] = alu_value;
      wake_k[i] = alu_value;
      for (int p = NUM_CDB - 1; p >= 0; p--) begin
        if (cdb_valid[p] && cdb_rob[p*ROB_ID_W +: ROB_ID_W] == tag_j[i]) begin
          hit_j[i] = 1'b1;
          wake_j[i] = cdb_value[p*32 +: 32];
        end
        if (cdb_valid[p] && cdb_rob[p*ROB_ID_W +: ROB_ID_W] == tag_k[i]) begin
          hit_k[i] = 1'b1;
          wake_k[i] = cdb_value[p*32 +: 32];
        end
      end
    end
  end
  rs_alu u_alu (
    .op(e_op[sel]),
    .vj(e_vj[sel]),
    .vk(e_vk[sel]),
    .imm(e_imm[sel]),
    .pc(e_pc[sel]),
    .value(alu_value),
    .target(alu_target)
  );
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      e_valid <= '0;
      for (int i = 0; i < DEPTH; i++) older[i] <= '0;
      count <= '0;
      out_valid <= 1'b0;
      out_rob <= '0;
      out_value <= '0;
      out_target <= '0;
    end else if (rdy_in) begin
      if (flush) begin
        e_valid <= '0;
        count <= '0;
        out_valid <= 1'b0;
      end else begin
        if (issue) begin
          e_valid[sel] <= 1'b0;
          out_valid <= 1'b1;
          out_rob <= e_rob[sel];
          out_value <= alu_value;
          out_target <= alu_target;
        end else if (out_ready) begin
          out_valid <= 1'b0;
        end
        if (disp_fire) begin
          e_valid[free_idx] <= 1'b1;
          older[free_idx] <= e_valid;
          for (int i = 0; i < DEPTH; i++) older[i][free_idx] <= 1'b0;
        end
        count <= count + CW'(disp_fire) - CW'(issue);
      end
    end
  end
  // payload needs no reset: e_valid gates every use of it
  always_ff @(posedge clk_in) begin
    if (rdy_in) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (!e_j[i] && hit_j[i]) begin
          e_j[i] <= 1'b1;
          e_vj[i] <= wake_j[i];
        end
        if (!e_k[i] && hit_k[i]) begin
          e_k[i] <= 1'b1;
          e_vk[i] <= wake_k[i];
        end
      end
      if (disp_fire) begin
        e_op[free_idx] <= disp_op;
        e_rob[free_idx] <= disp_rob;
        e_imm[free_idx] <= disp_imm;
        e_pc[free_idx] <= disp_pc;
        e_qj[free_idx] <= disp_qj;
        e_qk[free_idx] <= disp_qk;
        e_j[free_idx] <= disp_j || hit_j[DEPTH];
        e_k[free_idx] <= disp_k || hit_k[DEPTH];
        e_vj[free_idx] <= disp_j ? disp_vj : wake_j[DEPTH];
        e_vk[free_idx] <= disp_k ? disp_vk : wake_k[DEPTH];
      end
    end
  end
endmodule

// File: tb/tb_age_rs.sv
// tb_age_rs: directed self-checking bench for the age-ordered reservation station
module tb_age_rs;
  logic clk_in = 1'b0;
  logic rst_in, rdy_in, flush;
  logic disp_valid, disp_ready, disp_j, disp_k;
  logic [5:0] disp_op;
  logic [3:0] disp_rob, disp_qj, disp_qk;
  logic [31:0] disp_imm, disp_pc, disp_vj, disp_vk;
  logic [1:0] cdb_valid;
  logic [7:0] cdb_rob;
  logic [63:0] cdb_value;
  logic out_valid, out_ready;
  logic [3:0] out_rob;
  logic [31:0] out_value, out_target;
  logic [3:0] count;
  int total = 0;
  int bad = 0;
  always #5 clk_in = ~clk_in;
  age_rs #(.DEPTH(8), .NUM_CDB(2), .ROB_ID_W(4)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .flush(flush),
    .disp_valid(disp_valid), .disp_ready(disp_ready), .disp_op(disp_op), .disp_rob(disp_rob),
    .disp_imm(disp_imm), .disp_pc(disp_pc), .disp_j(disp_j), .disp_k(disp_k),
    .disp_vj(disp_vj), .disp_vk(disp_vk), .disp_qj(disp_qj), .disp_qk(disp_qk),
    .cdb_valid(cdb_valid), .cdb_rob(cdb_rob), .cdb_value(cdb_value),
    .out_valid(out_valid), .out_ready(out_ready), .out_rob(out_rob),
    .out_value(out_value), .out_target(out_target), .count(count)
  );
  task automatic tick;
    @(posedge clk_in);
    #1;
  endtask
  task automatic disp(input logic [5:0] op, input logic [3:0] rob, input logic j, input logic [3:0] qj,
                      input logic [31:0] vj, input logic k, input logic [3:0] qk, input logic [31:0] vk,
                      input logic [31:0] imm, input logic [31:0] pc);
    disp_valid = 1'b1;
    disp_op = op;
    disp_rob = rob;
    disp_j = j;
    disp_qj = qj;
    disp_vj = vj;
    disp_k = k;
    disp_qk = qk;
    disp_vk = vk;
    disp_imm = imm;
    disp_pc = pc;
    tick();
    disp_valid = 1'b0;
  endtask
  task automatic rdisp(input logic [5:0] op, input logic [3:0] rob, input logic [31:0] vj, input logic [31:0] vk, input logic [31:0] imm);
    disp(op, rob, 1'b1, 4'd0, vj, 1'b1, 4'd0, vk, imm, 32'd0);
  endtask
  task automatic test_reset;
    rst_in = 1'b1; rdy_in = 1'b1; flush = 1'b0; out_ready = 1'b1;
    disp_valid = 1'b0; disp_op = '0; disp_rob = '0; disp_imm = '0; disp_pc = '0;
    disp_j = 1'b0; disp_k = 1'b0; disp_vj = '0; disp_vk = '0; disp_qj = '0; disp_qk = '0;
    cdb_valid = '0; cdb_rob = '0; cdb_value = '0;
    repeat (2) tick();
    total++; if (count !== 4'd0) begin bad++; $display("FAIL reset_count got %0d want 0", count); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    total++; if ({out_rob, out_value, out_target} !== 68'd0) begin bad++; $display("FAIL reset_out_regs got %h %h %h want 0", out_rob, out_value, out_target); end
    total++; if (disp_ready !== 1'b1) begin bad++; $display("FAIL reset_disp_ready got %b want 1", disp_ready); end
    rst_in = 1'b0;
  endtask
  task automatic test_addi;
    rdisp(6'd18, 4'd2, 32'd5, 32'd0, 32'd3);
    total++; if (out_valid !== 1'b0 || count !== 4'd1) begin bad++; $display("FAIL addi_latency got valid=%b count=%0d want 0 1", out_valid, count); end
    tick();
    total++; if (out_valid !== 1'b1 || out_rob !== 4'd2 || out_value !== 32'd8) begin bad++; $display("FAIL addi_result got v=%b rob=%0d val=%0d want 1 2 8", out_valid, out_rob, out_value); end
    total++; if (count !== 4'd0) begin bad++; $display("FAIL addi_count got %0d want 0", count); end
    tick();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL addi_drain got %b want 0", out_valid); end
  endtask
  task automatic test_cdb;
    disp(6'd27, 4'd4, 1'b0, 4'd3, 32'd0, 1'b1, 4'd0, 32'd1, 32'd0, 32'd0);
    cdb_valid = 2'b11; cdb_rob = {4'd3, 4'd3}; cdb_value = {32'd99, 32'd10};
    tick();
    cdb_valid = 2'b00;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL cdb_wait got %b want 0", out_valid); end
    tick();
    total++; if (out_valid !== 1'b1 || out_rob !== 4'd4 || out_value !== 32'd11) begin bad++; $display("FAIL cdb_wake got v=%b rob=%0d val=%0d want 1 4 11", out_valid, out_rob, out_value); end
    tick();
    cdb_valid = 2'b10; cdb_rob = {4'd12, 4'd0}; cdb_value = {32'd5, 32'd0};
    disp(6'd27, 4'd5, 1'b0, 4'd12, 32'd0, 1'b1, 4'd0, 32'd3, 32'd0, 32'd0);
    cdb_valid = 2'b00;
    tick();
    total++; if (out_valid !== 1'b1 || out_rob !== 4'd5 || out_value !== 32'd8) begin bad++; $display("FAIL cdb_disp_capture got v=%b rob=%0d val=%0d want 1 5 8", out_valid, out_rob, out_value); end
    tick();
  endtask
  task automatic test_bypass;
    rdisp(6'd18, 4'd1, 32'd1, 32'd0, 32'd2);
    disp(6'd27, 4'd5, 1'b0, 4'd1, 32'd0, 1'b1, 4'd0, 32'd10, 32'd0, 32'd0);
    total++; if (out_rob !== 4'd1 || out_value !== 32'd3) begin bad++; $display("FAIL byp_first got rob=%0d val=%0d want 1 3", out_rob, out_value); end
    tick();
    total++; if (out_valid !== 1'b1 || out_rob !== 4'd5 || out_value !== 32'd13) begin bad++; $display("FAIL byp_disp got v=%b rob=%0d val=%0d want 1 5 13", out_valid, out_rob, out_value); end
    tick();
    disp(6'd27, 4'd7, 1'b0, 4'd6, 32'd0, 1'b1, 4'd0, 32'd100, 32'd0, 32'd0);
    rdisp(6'd18, 4'd6, 32'd20, 32'd0, 32'd0);
    tick();
    total++; if (out_rob !== 4'd6 || out_value !== 32'd20) begin bad++; $display("FAIL byp_producer got rob=%0d val=%0d want 6 20", out_rob, out_value); end
    tick();
    total++; if (out_valid !== 1'b1 || out_rob !== 4'd7 || out_value !== 32'd120) begin bad++; $display("FAIL byp_waiter got v=%b rob=%0d val=%0d want 1 7 120", out_valid, out_rob, out_value); end
    tick();
  endtask
  task automatic test_full;
    for (int i = 0; i < 8; i++) disp(6'd27, 4'(i), 1'b0, 4'(8 + i), 32'd0, 1'b1, 4'd0, 32'd0, 32'd0, 32'd0);
    total++; if (count !== 4'd8 || disp_ready !== 1'b0) begin bad++; $display("FAIL full_state got count=%0d ready=%b want 8 0", count, disp_ready); end
    rdisp(6'd18, 4'd15, 32'd1, 32'd0, 32'd1);
    total++; if (count !== 4'd8) begin bad++; $display("FAIL full_ignore got count=%0d want 8", count); end
    cdb_valid = 2'b01; cdb_rob = {4'd0, 4'd8}; cdb_value = {32'd0, 32'd7};
    tick();
    cdb_valid = 2'b00;
    tick();
    total++; if (out_valid !== 1'b1 || out_rob !== 4'd0 || out_value !== 32'd7) begin bad++; $display("FAIL full_issue got v=%b rob=%0d val=%0d want 1 0 7", out_valid, out_rob, out_value); end
    total++; if (count !== 4'd7 || disp_ready !== 1'b1) begin bad++; $display("FAIL full_release got count=%0d ready=%b want 7 1", count, disp_ready); end
    flush = 1'b1;
    tick();
    flush = 1'b0;
  endtask
  task automatic test_age;
    for (int i = 0; i < 5; i++) disp(6'd27, 4'(i), 1'b0, 4'd10, 32'd0, 1'b1, 4'd0, 32'd0, 32'd0, 32'd0);
    disp(6'd27, 4'd5, 1'b0, 4'd11, 32'd0, 1'b1, 4'd0, 32'd1, 32'd0, 32'd0);
    cdb_valid = 2'b01; cdb_rob = {4'd0, 4'd10}; cdb_value = {32'd0, 32'd1};
    tick();
    cdb_valid = 2'b00;
    repeat (7) tick();
    total++; if (count !== 4'd1) begin bad++; $display("FAIL age_setup got count=%0d want 1", count); end
    disp(6'd27, 4'd6, 1'b0, 4'd12, 32'd0, 1'b1, 4'd0, 32'd2, 32'd0, 32'd0);
    cdb_valid = 2'b11; cdb_rob = {4'd12, 4'd11}; cdb_value = {32'd60, 32'd50};
    tick();
    cdb_valid = 2'b00;
    tick();
    total++; if (out_rob !== 4'd5 || out_value !== 32'd51) begin bad++; $display("FAIL age_oldest got rob=%0d val=%0d want 5 51", out_rob, out_value); end
    tick();
    total++; if (out_rob !== 4'd6 || out_value !== 32'd62) begin bad++; $display("FAIL age_second got rob=%0d val=%0d want 6 62", out_rob, out_value); end
    tick();
  endtask
  task automatic test_stall;
    out_ready = 1'b0;
    for (int i = 1; i <= 3; i++) rdisp(6'd18, 4'(i), 32'(i), 32'd0, 32'd10);
    total++; if (out_valid !== 1'b1 || out_rob !== 4'd1 || out_value !== 32'd11 || count !== 4'd2) begin bad++; $display("FAIL stall_start got v=%b rob=%0d val=%0d count=%0d want 1 1 11 2", out_valid, out_rob, out_value, count); end
    for (int c = 0; c < 3; c++) begin
      tick();
      total++; if (out_valid !== 1'b1 || out_rob !== 4'd1 || out_value !== 32'd11 || count !== 4'd2) begin bad++; $display("FAIL stall_hold got v=%b rob=%0d val=%0d count=%0d want 1 1 11 2", out_valid, out_rob, out_value, count); end
    end
    out_ready = 1'b1;
    tick();
    total++; if (out_rob !== 4'd2 || out_value !== 32'd12) begin bad++; $display("FAIL stall_next got rob=%0d val=%0d want 2 12", out_rob, out_value); end
    tick();
    total++; if (out_rob !== 4'd3 || out_value !== 32'd13) begin bad++; $display("FAIL stall_last got rob=%0d val=%0d want 3 13", out_rob, out_value); end
    tick();
    total++; if (out_valid !== 1'b0 || count !== 4'd0) begin bad++; $display("FAIL stall_empty got v=%b count=%0d want 0 0", out_valid, count); end
  endtask
  task automatic test_flush;
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) rdisp(6'd18, 4'(i + 1), 32'(i), 32'd0, 32'd1);
    total++; if (count !== 4'd4 || out_valid !== 1'b1) begin bad++; $display("FAIL flush_setup got count=%0d v=%b want 4 1", count, out_valid); end
    flush = 1'b1;
    disp_valid = 1'b1;
    tick();
    flush = 1'b0;
    disp_valid = 1'b0;
    total++; if (count !== 4'd0 || out_valid !== 1'b0) begin bad++; $display("FAIL flush_clear got count=%0d v=%b want 0 0", count, out_valid); end
    out_ready = 1'b1;
    tick();
    total++; if (count !== 4'd0 || out_valid !== 1'b0) begin bad++; $display("FAIL flush_discard got count=%0d v=%b want 0 0", count, out_valid); end
  endtask
  task automatic test_freeze;
    rdisp(6'd18, 4'd3, 32'd4, 32'd0, 32'd4);
    rdy_in = 1'b0;
    disp_valid = 1'b1; disp_rob = 4'd9;
    cdb_valid = 2'b01; cdb_rob = {4'd0, 4'd3}; cdb_value = {32'd0, 32'd1};
    repeat (2) tick();
    total++; if (count !== 4'd1 || out_valid !== 1'b0) begin bad++; $display("FAIL freeze_hold got count=%0d v=%b want 1 0", count, out_valid); end
    rdy_in = 1'b1;
    disp_valid = 1'b0;
    cdb_valid = 2'b00;
    tick();
    total++; if (out_valid !== 1'b1 || out_rob !== 4'd3 || out_value !== 32'd8 || count !== 4'd0) begin bad++; $display("FAIL freeze_resume got v=%b rob=%0d val=%0d count=%0d want 1 3 8 0", out_valid, out_rob, out_value, count); end
    tick();
  endtask
  task automatic test_async_reset;
    out_ready = 1'b0;
    rdisp(6'd18, 4'd7, 32'd1, 32'd0, 32'd1);
    rdisp(6'd18, 4'd8, 32'd1, 32'd0, 32'd2);
    total++; if (out_rob !== 4'd7 || count !== 4'd1) begin bad++; $display("FAIL arst_setup got rob=%0d count=%0d want 7 1", out_rob, count); end
    #3;
    rst_in = 1'b1;
    #1;
    total++; if (out_valid !== 1'b0 || {out_rob, out_value, out_target} !== 68'd0 || count !== 4'd0) begin bad++; $display("FAIL arst_immediate got v=%b rob=%0d val=%h tgt=%h count=%0d want all 0", out_valid, out_rob, out_value, out_target, count); end
    #2;
    rst_in = 1'b0;
    out_ready = 1'b1;
    rdisp(6'd18, 4'd2, 32'd9, 32'd0, 32'd1);
    total++; if (count !== 4'd1) begin bad++; $display("FAIL arst_first_disp got count=%0d want 1", count); end
    tick();
    total++; if (out_rob !== 4'd2 || out_value !== 32'd10 || count !== 4'd0) begin bad++; $display("FAIL arst_dropped got rob=%0d val=%0d count=%0d want 2 10 0", out_rob, out_value, count); end
    tick();
  endtask
  task automatic test_alu;
    logic [5:0] ops [20];
    logic [31:0] vjs [20];
    logic [31:0] vks [20];
    logic [31:0] imms [20];
    logic [31:0] pcs [20];
    logic [31:0] evs [20];
    logic [31:0] ets [20];
    ops = '{6'd0, 6'd1, 6'd2, 6'd3, 6'd4, 6'd5, 6'd6, 6'd7, 6'd8, 6'd9, 6'd24, 6'd26, 6'd34, 6'd28, 6'd20, 6'd30, 6'd33, 6'd12, 6'd32, 6'd23};
    vjs = '{32'h0, 32'h0, 32'h0, 32'h203, 32'h3, 32'h3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF,
            32'h1, 32'h80000000, 32'h80000000, 32'h5, 32'h1, 32'hFFFFFFFE, 32'h80000000, 32'h5, 32'hF0F0, 32'hFFFF};
    vks = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h3, 32'h3, 32'h1, 32'h1, 32'h1, 32'h1,
            32'h0, 32'h0, 32'h21, 32'h7, 32'h0, 32'h1, 32'h3F, 32'h5, 32'hFF00, 32'h0};
    imms = '{32'h12345000, 32'hABC00000, 32'h20, 32'h4, 32'h10, 32'h10, 32'h10, 32'h10, 32'h10, 32'h10,
             32'h23, 32'h401, 32'h0, 32'h0, 32'hFFFFFFFF, 32'h0, 32'h0, 32'h5, 32'h0, 32'h0F0F};
    pcs = '{32'h0, 32'h0, 32'h100, 32'h100, 32'h40, 32'h40, 32'h40, 32'h40, 32'h40, 32'h40,
            32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h5, 32'h0, 32'h0};
    evs = '{32'h12345000, 32'hABC00000, 32'h104, 32'h104, 32'h1, 32'h0, 32'h1, 32'h0, 32'h0, 32'h1,
            32'h8, 32'hC0000000, 32'hC0000000, 32'hFFFFFFFE, 32'h1, 32'h1, 32'h1, 32'h0, 32'h0FF0, 32'h0F0F};
    ets = '{32'h0, 32'h0, 32'h120, 32'h206, 32'h50, 32'h50, 32'h50, 32'h50, 32'h50, 32'h50,
            32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
    for (int i = 0; i < 20; i++) begin
      disp(ops[i], 4'(i), 1'b1, 4'd0, vjs[i], 1'b1, 4'd0, vks[i], imms[i], pcs[i]);
      tick();
      total++; if (out_valid !== 1'b1 || out_value !== evs[i] || out_target !== ets[i]) begin bad++; $display("FAIL alu_op%0d got v=%b val=%h tgt=%h want 1 %h %h", ops[i], out_valid, out_value, out_target, evs[i], ets[i]); end
      tick();
    end
  endtask
  initial begin
    test_reset();
    test_addi();
    test_cdb();
    test_bypass();
    test_full();
    test_age();
    test_stall();
    test_flush();
    test_freeze();
    test_async_reset();
    test_alu();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/age_rs.md
AGE_RS -- requirements
Module: age_rs

Interface
REQ-001 SHALL provide parameter DEPTH, default 8, entry count (power of two, 2..32).
REQ-002 SHALL provide parameter NUM_CDB, default 2, external wakeup broadcast ports.
REQ-003 SHALL provide parameter ROB_ID_W, default `ROB_WIDTH_BIT, ROB tag width.
REQ-004 SHALL have port clk_in  in  1  the block's only clock.
REQ-005 SHALL have port rst_in  in  1  reset; asynchronous, active-high.
REQ-006 SHALL have port rdy_in  in  1  global pause; low freezes all state.
REQ-007 SHALL have port flush  in  1  mispredict clear from ROB.
REQ-008 SHALL have dispatch ports disp_valid in 1, disp_ready out 1, disp_op in 6, disp_rob in ROB_ID_W, disp_imm in 32, disp_pc in 32.
REQ-009 SHALL have operand ports disp_j/disp_k in 1 (operand ready), disp_vj/disp_vk in 32, disp_qj/disp_qk in ROB_ID_W.
REQ-010 SHALL have wakeup ports cdb_valid in NUM_CDB, cdb_rob in NUM_CDB*ROB_ID_W, cdb_value in NUM_CDB*32.
REQ-011 SHALL have result ports out_valid out 1, out_ready in 1, out_rob out ROB_ID_W, out_value out 32, out_target out 32.
REQ-012 SHALL have port count  out  $clog2(DEPTH+1)  occupied entries.

Function
REQ-013 disp_ready SHALL equal (count < DEPTH); dispatch occurs on an edge with rdy_in & disp_valid & disp_ready & !flush; lowest-index free entry is written.
REQ-014 Dispatch with disp_valid while disp_ready low SHALL be ignored, no state change.
REQ-015 Each entry SHALL record age; select SHALL pick the oldest entry with j&k set (age matrix, not index priority).
REQ-016 Issue SHALL occur when an entry is ready and (out_valid==0 or out_ready==1); the entry frees and the output register loads at that edge.
REQ-017 Output register SHALL hold out_valid/out_rob/out_value/out_target stable while out_valid & !out_ready.
REQ-018 Minimum latency SHALL be 2 edges: dispatch at edge N with both operands ready -> out_valid high after edge N+1.
REQ-019 On issue, the computed value SHALL wake any waiting entry whose q tag matches out_rob at the same edge (internal bypass).
REQ-020 Any cdb_valid[i] with matching q tag SHALL set j/k and capture value; a tag matched by several ports SHALL take lowest port index.
REQ-021 Dispatch SHALL capture an operand broadcast (CDB or internal issue) in the same cycle, so no entry waits on an already-produced tag.
REQ-022 Simultaneous dispatch and issue SHALL leave count unchanged; count SHALL never exceed DEPTH nor underflow.
REQ-023 ALU SHALL use team op codes 0-9, 18-36: lui/auipc value=imm; jal value=pc+4; jalr value=pc+4, target=(vj+imm)&~1; branches 4-9 value 1 if taken else 0, target=pc+imm.
REQ-024 All shifts (I and R forms) SHALL use bits [4:0] of shamt; unknown op SHALL yield value 0, target 0.
REQ-025 flush with rdy_in high SHALL clear all entries, count and out_valid at that edge and discard same-cycle dispatch.
REQ-026 rdy_in low SHALL freeze entries, count and outputs; CDB and dispatch ignored.

Reset
REQ-027 rst_in high SHALL asynchronously clear all entry valid bits, ages, count=0, out_valid=0, out_rob/out_value/out_target=0.
REQ-028 Reset mid-operation SHALL drop all pending entries; first dispatch accepted on the first edge after deassertion.

Structure
REQ-029 Op-code constants, ROB_WIDTH_BIT and RS default depth SHALL live in shared const.v.
REQ-030 Combinational value/target computation SHALL be sub-module rs_alu (op, vj, vk, imm, pc -> value, target).

Verification
REQ-031 Dispatch addi vj=5 imm=3 rob=2 ready -> out_valid 2 edges later, out_rob=2, out_value=8.
REQ-032 Dispatch add waiting qj=3 (rob=4), then cdb rob=3 value=10, vk=1 -> out_value=11, out_rob=4.
REQ-033 Fill DEPTH unready entries -> disp_ready=0, count=DEPTH; extra dispatch ignored; one wakeup+issue -> disp_ready=1.
REQ-034 Entries A (older, index 5) and B (index 0) become ready same cycle -> A issues first.
REQ-035 Hold out_ready=0 for 3 cycles with ready entries -> outputs stable, no entry lost; release -> sequential issue.
REQ-036 flush with 4 entries and out_valid high -> count=0, out_valid=0 next edge; async rst_in mid-cycle -> outputs 0 immediately.
